dmem_arbiter: RTL and testbench

Shares the single-port data memory between the processor's load/store path (port 0) and an external loader/debug master (port 1). Each cycle it grants at most one requester and drives the memory control, address and write data. It returns synchronous read data to the granted port one cycle later. Port 0 has fixed priority, bounded by an anti-starvation counter, so port 1 is always serviced within a fixed number of cycles. The block sits between the processor datapath and `Data_Memory`; it turns the processor's combinational `mem_read`/`mem_write` into a stallable request.

---
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: processor load/store (port 0)
// has fixed priority, bounded by a starvation counter that guarantees port 1 service.
module dmem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int MAX_CONSEC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_stall,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        starve_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RD0  = 3'b010,
        RD1  = 3'b100
    } state_t;

    localparam logic [3:0] MAX_C = 4'(MAX_CONSEC);

    state_t     state;
    logic [3:0] starve_q;
    logic [1:0] rd_owner;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= MAX_C) ? MAX_C : v + 4'd1;
    endfunction

    // Grants are gated by reset so nothing reaches the memory during reset cycles.
    always_comb begin
        p1_gnt = ~reset & p1_req & (~p0_req | (starve_q == MAX_C));
        p0_gnt = ~reset & p0_req & ~p1_gnt;
    end

    assign p0_stall   = p0_req & ~p0_gnt;
    assign starve_cnt = starve_q;

    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (p1_gnt) begin
            mem_re    = ~p1_we;
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end else if (p0_gnt) begin
            mem_re    = ~p0_we;
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end
    end

    // Owner encoding: 00 none, 01 port 0, 10 port 1.
    assign rd_owner = {state == RD1, state == RD0};

    // A pending return is dropped if reset lands on its delivery cycle.
    always_comb begin
        p0_rvalid = rd_owner[0] & ~reset;
        p1_rvalid = rd_owner[1] & ~reset;
        p0_rdata  = p0_rvalid ? mem_rdata : '0;
        p1_rdata  = p1_rvalid ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            starve_q <= 4'd0;
        end else begin
            if (p0_gnt && !p0_we)
                state <= RD0;
            else if (p1_gnt && !p1_we)
                state <= RD1;
            else
                state <= IDLE;

            if (!p1_req || p1_gnt)
                starve_q <= 4'd0;
            else if (p0_gnt)
                starve_q <= sat_inc(starve_q);
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory behind it.
module tb_dmem_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic              clk;
    logic              reset;
    logic              p0_req, p0_we, p1_req, p1_we;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wdata, p1_wdata;
    logic              p0_gnt, p0_stall, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic              mem_re, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [3:0]        starve_cnt;

    logic [DATA_W-1:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CONSEC(4)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_stall(p0_stall), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks run 1ns later, far from posedge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h20] = 16'h1234;
        mem[8'h21] = 16'h5678;
        mem_rdata  = '0;

        reset = 1'b1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h30; p0_wdata = '0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h31; p1_wdata = '0;

        for (int c = 0; c < 2; c++) begin
            next_cycle();
            #1;
            chk("rst_p0_gnt", 32'(p0_gnt), 32'd0);
            chk("rst_p1_gnt", 32'(p1_gnt), 32'd0);
            chk("rst_mem_re", 32'(mem_re), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
            chk("rst_starve", 32'(starve_cnt), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        end

        // Continuous contention: p0 x4, p1, p0 x4, p1
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) next_cycle();
            #1;
            chk("cont_p1_gnt", 32'(p1_gnt), 32'(i % 5 == 4));
            chk("cont_p0_gnt", 32'(p0_gnt), 32'(i % 5 != 4));
            chk("cont_p0_stall", 32'(p0_stall), 32'(i % 5 == 4));
            chk("cont_starve", 32'(starve_cnt), 32'(i % 5));
            chk("cont_mem_addr", 32'(mem_addr), (i % 5 == 4) ? 32'h31 : 32'h30);
            chk("cont_mem_re", 32'(mem_re), 32'd1);
            if (i > 0) begin
                chk("cont_p1_rvalid", 32'(p1_rvalid), 32'((i - 1) % 5 == 4));
                chk("cont_p0_rvalid", 32'(p0_rvalid), 32'((i - 1) % 5 != 4));
            end
        end

        // Solo port 0: write then read back
        next_cycle();
        p1_req = 1'b0;
        p0_we = 1'b1; p0_addr = 8'h10; p0_wdata = 16'hBEEF;
        #1;
        chk("wr_p0_gnt", 32'(p0_gnt), 32'd1);
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_re", 32'(mem_re), 32'd0);
        chk("wr_mem_addr", 32'(mem_addr), 32'h10);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        chk("wr_p0_stall", 32'(p0_stall), 32'd0);
        chk("wr_starve", 32'(starve_cnt), 32'd0);
        chk("wr_p1_rvalid", 32'(p1_rvalid), 32'd1);

        next_cycle();
        p0_we = 1'b0; p0_wdata = '0;
        #1;
        chk("rd_mem_re", 32'(mem_re), 32'd1);
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        chk("rd_mem_addr", 32'(mem_addr), 32'h10);
        chk("rd_p0_stall", 32'(p0_stall), 32'd0);
        chk("wr_no_rvalid", 32'(p0_rvalid), 32'd0);

        next_cycle();
        p0_req = 1'b0;
        #1;
        chk("rd_p0_rvalid", 32'(p0_rvalid), 32'd1);
        chk("rd_p0_rdata", 32'(p0_rdata), 32'hBEEF);
        chk("rd_p1_rvalid", 32'(p1_rvalid), 32'd0);
        chk("rd_p1_rdata", 32'(p1_rdata), 32'd0);
        chk("idle_mem_re", 32'(mem_re), 32'd0);
        chk("idle_mem_addr", 32'(mem_addr), 32'd0);

        // Routing: p1 reads 0x20 alone, then p0 reads 0x21
        next_cycle();
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h20;
        #1;
        chk("p1solo_gnt", 32'(p1_gnt), 32'd1);
        chk("p1solo_p0_gnt", 32'(p0_gnt), 32'd0);
        chk("p1solo_mem_addr", 32'(mem_addr), 32'h20);
        chk("p1solo_starve", 32'(starve_cnt), 32'd0);

        next_cycle();
        p1_req = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h21;
        #1;
        chk("route_p0_gnt", 32'(p0_gnt), 32'd1);
        chk("route_p1_rvalid", 32'(p1_rvalid), 32'd1);
        chk("route_p1_rdata", 32'(p1_rdata), 32'h1234);
        chk("route_p0_rvalid_a", 32'(p0_rvalid), 32'd0);
        chk("route_p0_rdata_a", 32'(p0_rdata), 32'd0);
        chk("route_starve", 32'(starve_cnt), 32'd0);

        next_cycle();
        p0_req = 1'b0;
        #1;
        chk("route_p0_rvalid", 32'(p0_rvalid), 32'd1);
        chk("route_p0_rdata", 32'(p0_rdata), 32'h5678);
        chk("route_p1_rvalid_b", 32'(p1_rvalid), 32'd0);
        chk("route_p1_rdata_b", 32'(p1_rdata), 32'd0);

        // Reset lands on the delivery cycle of a p0 read
        next_cycle();
        p0_req = 1'b1; p0_addr = 8'h21;
        #1;
        chk("mid_p0_gnt", 32'(p0_gnt), 32'd1);

        next_cycle();
        p0_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rvalid_suppr", 32'(p0_rvalid), 32'd0);
        chk("mid_rdata_zero", 32'(p0_rdata), 32'd0);

        next_cycle();
        reset = 1'b0;
        #1;
        chk("mid_owner_clr", 32'(p0_rvalid), 32'd0);
        chk("mid_starve", 32'(starve_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
